// File: rtl/t_toggle_decoder.sv
// Recovers T-flop events from a slow toggling level: sync, debounce, one-cycle pulses, saturating count.
// Latency SYNC_STAGES+STABLE_CYCLES edges from q_in change to pulse; no backpressure, pulses are fire-and-forget.
module t_toggle_decoder #(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 1000,
   parameter int CNT_WIDTH     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 q_in,
   input  logic                 clr_cnt,
   output logic                 level_out,
   output logic                 t_pulse,
   output logic                 rise_pulse,
   output logic                 fall_pulse,
   output logic [CNT_WIDTH-1:0] event_cnt,
   output logic                 cnt_sat
);

   localparam int TW = $clog2(STABLE_CYCLES + 1);
   localparam logic [TW-1:0] TIMER_MAX = TW'(STABLE_CYCLES);

   typedef enum logic {
      ST_STABLE,
      ST_CONFIRM
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   q_s;
   state_t                 state;
   logic [TW-1:0]          timer;

   assign q_s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], q_in};
      end
   end

   // A change is accepted only after STABLE_CYCLES+1 consecutive differing samples.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_STABLE;
         timer      <= '0;
         level_out  <= 1'b0;
         t_pulse    <= 1'b0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
      end else begin
         t_pulse    <= 1'b0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
         case (state)
            ST_STABLE: begin
               if (q_s != level_out) begin
                  state <= ST_CONFIRM;
                  timer <= TW'(1);
               end else begin
                  timer <= '0;
               end
            end
            ST_CONFIRM: begin
               if (q_s == level_out) begin
                  state <= ST_STABLE;
                  timer <= '0;
               end else if (timer == TIMER_MAX) begin
                  level_out  <= q_s;
                  t_pulse    <= 1'b1;
                  rise_pulse <= q_s;
                  fall_pulse <= ~q_s;
                  state      <= ST_STABLE;
                  timer      <= '0;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            default: begin
               state <= ST_STABLE;
               timer <= '0;
            end
         endcase
      end
   end

   // A clear that lands on a pulse cycle still counts that event.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         event_cnt <= '0;
         cnt_sat   <= 1'b0;
      end else if (clr_cnt) begin
         event_cnt <= t_pulse ? CNT_WIDTH'(1) : '0;
         cnt_sat   <= 1'b0;
      end else if (t_pulse) begin
         if (event_cnt == {CNT_WIDTH{1'b1}}) begin
            cnt_sat <= 1'b1;
         end else begin
            event_cnt <= event_cnt + CNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_t_toggle_decoder.sv
// Bench for t_toggle_decoder: directed scenarios plus random q_in, checked by a scoreboard fed from a reference model.
module tb_t_toggle_decoder;

   localparam int SS = 2;
   localparam int SC = 4;
   localparam int CW = 3;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          q_in = 1'b0;
   logic          clr_cnt = 1'b0;
   logic          level_out, t_pulse, rise_pulse, fall_pulse, cnt_sat;
   logic [CW-1:0] event_cnt;

   t_toggle_decoder #(.SYNC_STAGES(SS), .STABLE_CYCLES(SC), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .q_in(q_in), .clr_cnt(clr_cnt),
      .level_out(level_out), .t_pulse(t_pulse), .rise_pulse(rise_pulse),
      .fall_pulse(fall_pulse), .event_cnt(event_cnt), .cnt_sat(cnt_sat)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   typedef struct {
      int t;
      bit lvl;
   } ev_t;

   ev_t exp_q[$];
   bit  hist[$];
   bit  m_level;
   int  run_len;
   bit  pulse_prev;
   int  m_cnt;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: q_in seen by the debouncer SS edges late; a level change is
   // taken once the delayed input has disagreed for SC+1 edges in a row.
   always @(posedge clk or posedge rst) begin
      bit s;
      if (rst) begin
         hist.delete();
         for (int i = 0; i < SS; i++) hist.push_back(1'b0);
         m_level    = 1'b0;
         run_len    = 0;
         pulse_prev = 1'b0;
         m_cnt      = 0;
         exp_q.delete();
      end else begin
         if (clr_cnt) m_cnt = pulse_prev ? 1 : 0;
         else if (pulse_prev && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
         s = hist.pop_front();
         hist.push_back(q_in);
         pulse_prev = 1'b0;
         if (s != m_level) begin
            run_len = run_len + 1;
            if (run_len == SC + 1) begin
               m_level    = s;
               run_len    = 0;
               pulse_prev = 1'b1;
               exp_q.push_back('{int'($time), s});
            end
         end else begin
            run_len = 0;
         end
      end
   end

   // Monitor: every pulse must match the next expected event in time and direction.
   always @(negedge clk) begin
      ev_t e;
      if (rst) begin
         chk("reset_outputs", int'({level_out, t_pulse, rise_pulse, fall_pulse, event_cnt, cnt_sat}), 0);
      end else begin
         if (t_pulse) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_pulse", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("pulse_time", int'($time) - 5, e.t);
               chk("pulse_rise", int'(rise_pulse), int'(e.lvl));
               chk("pulse_fall", int'(fall_pulse), int'(!e.lvl));
            end
         end else begin
            chk("idle_dir_pulses", int'({rise_pulse, fall_pulse}), 0);
         end
         chk("level_out", int'(level_out), int'(m_level));
         chk("event_cnt", int'(event_cnt), m_cnt);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   // Edges counted from the first edge after the call (edge 0) to the pulse edge.
   task automatic edges_to_pulse(output int n);
      n = -1;
      repeat (40) begin
         @(posedge clk);
         #1;
         n++;
         if (t_pulse) return;
      end
      n = 99;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int n;
      bit found;

      // 1: q_in high through reset is a real rise after release
      rst = 1'b1; q_in = 1'b1;
      cyc(3);
      rst = 1'b0;
      edges_to_pulse(n);
      chk("t1_latency", n, 6);
      chk("t1_rise", int'(rise_pulse), 1);
      cyc(2);
      chk("t1_pulse_width", int'(t_pulse), 0);
      chk("t1_level", int'(level_out), 1);
      chk("t1_cnt", int'(event_cnt), 1);

      // 2: clean rise then fall
      rst = 1'b1; q_in = 1'b0;
      cyc(2);
      rst = 1'b0;
      cyc(2);
      q_in = 1'b1;
      edges_to_pulse(n);
      chk("t2_rise_latency", n, 6);
      chk("t2_rise", int'(rise_pulse), 1);
      cyc(5);
      q_in = 1'b0;
      edges_to_pulse(n);
      chk("t2_fall_latency", n, 6);
      chk("t2_fall", int'(fall_pulse), 1);
      cyc(2);
      chk("t2_cnt", int'(event_cnt), 2);

      // 3: three-cycle glitch is rejected
      q_in = 1'b1;
      cyc(3);
      q_in = 1'b0;
      cyc(15);
      chk("t3_level", int'(level_out), 0);
      chk("t3_cnt", int'(event_cnt), 2);

      // 4: saturation then clear
      for (int i = 0; i < 9; i++) begin
         q_in = ~q_in;
         cyc(8);
      end
      cyc(4);
      chk("t4_cnt_sat_value", int'(event_cnt), 7);
      chk("t4_sat_flag", int'(cnt_sat), 1);
      clr_cnt = 1'b1;
      cyc(1);
      clr_cnt = 1'b0;
      chk("t4_clr_cnt", int'(event_cnt), 0);
      chk("t4_clr_sat", int'(cnt_sat), 0);

      // 5: clear on the pulse cycle keeps that event
      for (int i = 0; i < 2; i++) begin
         q_in = ~q_in;
         cyc(8);
      end
      chk("t5_pre_cnt", int'(event_cnt), 2);
      q_in = ~q_in;
      found = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (t_pulse) begin
            found = 1'b1;
            break;
         end
      end
      chk("t5_pulse_seen", int'(found), 1);
      #1;
      clr_cnt = 1'b1;
      cyc(1);
      clr_cnt = 1'b0;
      chk("t5_collision_cnt", int'(event_cnt), 1);
      cyc(8);

      // 6: reset mid-confirm aborts the pending rise; it comes back after release
      q_in = 1'b0;
      cyc(8);
      q_in = 1'b1;
      cyc(4);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      edges_to_pulse(n);
      chk("t6_latency_after_reset", n, 6);
      chk("t6_rise", int'(rise_pulse), 1);
      cyc(4);

      // random q_in with occasional clears
      for (int seg = 0; seg < 200; seg++) begin
         int hold;
         if ($urandom_range(0, 2) != 0) q_in = ~q_in;
         hold = $urandom_range(1, 10);
         for (int c = 0; c < hold; c++) begin
            clr_cnt = ($urandom_range(0, 15) == 0);
            cyc(1);
         end
      end
      clr_cnt = 1'b0;
      cyc(12);
      chk("queue_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
